vote_ballot_driver: RTL and testbench
=====================================

// Module: vote_ballot_driver
// PURPOSE
//  Producer side of the voter interface: accepts individual ballot events over a
//  valid/ready handshake, maintains staged np/vip/vvip vote vectors, and publishes
//  them once per round to the VoterPlus counter. It also publishes an
//  incrementally tracked weighted tally. The bench compares this tally against
//  the counter's result.
// PARAMETERS
//  NP_W     32  number of normal voters (np width)
//  VIP_W    8   number of VIP voters (vip width)
//  W_NP     1   vote weight of a normal voter
//  W_VIP    4   vote weight of a VIP voter
//  W_VVIP   16  vote weight of the single VVIP voter
//  TALLY_W  8   tally width (max 32*1+8*4+16 = 80 fits)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        synchronous, active-high reset
//  in_valid   in   1        ballot event present
//  in_ready   out  1        block can accept a ballot this cycle
//  in_class   in   2        0=np, 1=vip, 2=vvip, 3=reserved
//  in_index   in   5        voter index within class
//  in_vote    in   1        1=vote yes, 0=withdraw vote
//  in_last    in   1        ballot closes the round; publish after it
//  np         out  NP_W     published normal-voter vector
//  vip        out  VIP_W    published VIP vector
//  vvip       out  1        published VVIP vote
//  tally      out  TALLY_W  published weighted tally
//  pub_valid  out  1        1-cycle pulse when np/vip/vvip/tally update
//  round_cnt  out  8        number of completed rounds, wraps 255->0
//  err        out  1        sticky illegal-ballot flag
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high.
//  - Reset values: every output and staging register is 0, in_ready=1, FSM=IDLE.
//  - Handshake: a ballot is accepted when in_valid && in_ready at the clock edge.
//  - FSM: IDLE -(accept, !in_last)-> COLLECT; IDLE/COLLECT -(accept && in_last)-> PUBLISH;
//    PUBLISH -> IDLE, unconditionally, after 1 cycle.
//  - PUBLISH cycle: in_ready=0, staged vectors and staged tally are copied to the
//    outputs, pub_valid=1, round_cnt++.
//  - Latency: outputs are valid and pub_valid is high on the cycle after in_last
//    is accepted.
//  - Staging and published values are separate. Ballots never alter published
//    outputs before PUBLISH. Staged vectors carry over between rounds; they are
//    not cleared.
//  - Tally arithmetic: the staged tally changes only when the addressed bit flips.
//    - 0->1 adds the class weight; 1->0 subtracts it.
//    - A repeated identical vote leaves the tally unchanged.
//    - The tally can never underflow or overflow.
//  - Legality: class 3, vip index >= VIP_W, or vvip index != 0 is illegal.
//    - An illegal ballot is accepted but ignored: no state or tally change.
//    - It sets err, which stays 1 until reset.
//  - Illegal ballot with in_last: the ballot is still ignored, err is set, and the
//    round still publishes.
//  - np index: all 5-bit indices are legal when NP_W=32.
//  - Reset mid-round or during PUBLISH: pending ballots are discarded and there is
//    no pub_valid.
// STRUCTURE
//  - Header vote_defs.vh: class encodings (CLS_NP/CLS_VIP/CLS_VVIP/CLS_RSV) and
//    default weights.
//  - Sub-module vote_stage_bank: staging vectors plus the bit-flip detector. It
//    outputs old_bit for the tally delta.
//  - Top level: FSM, tally accumulator, publish registers and round counter.
// TESTING
//  1 Reset: hold reset for 3 cycles.
//    -> np=0, vip=0, vvip=0, tally=0, round_cnt=0, err=0, in_ready=1.
//  2 Three np yes votes (idx 0, 5, 31), then vip idx 2 with in_last.
//    -> next cycle pub_valid=1, np=32'h8000_0021, vip=8'h04, tally=7, round_cnt=1.
//  3 Round 2: vvip yes, np idx 5 withdraw, np idx 0 yes again (last).
//    -> np=32'h8000_0001, vvip=1, tally=22.
//  4 Illegal ballots: class 3, then vip idx 9, then np idx 1 with last.
//    -> err=1 and stays 1; np gains bit 1; tally +1; publish still occurs.
//  5 Backpressure: hold in_valid high through PUBLISH.
//    -> in_ready=0 for exactly 1 cycle and no ballot is lost; assert reset
//    mid-round -> all outputs return to 0.
//  6 Set all 32 np, 8 vip and vvip bits, then publish.
//    -> tally=80. Drive 256 empty rounds -> round_cnt wraps to the same value.
//    Cross-check tally against VoterPlus result each round.

Source files
------------

// File: rtl/vote_ballot_driver_pkg.sv
// Shared types, default sizing and helpers for the ballot driver.
package vote_ballot_driver_pkg;

    // Ballot class encodings as carried on in_class.
    typedef enum logic [1:0] {
        CLS_NP   = 2'd0,
        CLS_VIP  = 2'd1,
        CLS_VVIP = 2'd2,
        CLS_RSV  = 2'd3
    } ballot_cls_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PUBLISH = 2'd2
    } drv_state_e;

    localparam int DEF_NP_W    = 32;
    localparam int DEF_VIP_W   = 8;
    localparam int DEF_W_NP    = 1;
    localparam int DEF_W_VIP   = 4;
    localparam int DEF_W_VVIP  = 16;
    localparam int DEF_TALLY_W = 8;
    localparam int IDX_W       = 5;

    // A ballot is legal when its class exists and the index addresses a real voter.
    function automatic logic ballot_legal(input logic [1:0] cls, input logic [IDX_W-1:0] idx,
                                          input int np_w, input int vip_w);
        logic ok;
        ok = 1'b0;
        case (ballot_cls_e'(cls))
            CLS_NP:   ok = (int'(idx) < np_w);
            CLS_VIP:  ok = (int'(idx) < vip_w);
            CLS_VVIP: ok = (idx == '0);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/vote_ballot_driver_stage_bank.sv
// Staged np/vip/vvip vectors with the next-value view and the addressed old bit.
module vote_ballot_driver_stage_bank
    import vote_ballot_driver_pkg::*;
#(
    parameter int NP_W  = DEF_NP_W,
    parameter int VIP_W = DEF_VIP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        cls,
    input  logic [IDX_W-1:0]  idx,
    input  logic              vote,
    output logic              old_bit,
    output logic [NP_W-1:0]   np_next,
    output logic [VIP_W-1:0]  vip_next,
    output logic              vvip_next
);

    localparam int VIP_IW = (VIP_W > 1) ? $clog2(VIP_W) : 1;

    logic [NP_W-1:0]  np_reg;
    logic [VIP_W-1:0] vip_reg;
    logic             vvip_reg;

    // Per-bit next value: only the addressed bit of the addressed class may change.
    for (genvar gi = 0; gi < NP_W; gi++) begin : g_np
        assign np_next[gi] = (wr_en && cls == CLS_NP && int'(idx) == gi) ? vote : np_reg[gi];
    end
    for (genvar gi = 0; gi < VIP_W; gi++) begin : g_vip
        assign vip_next[gi] = (wr_en && cls == CLS_VIP && int'(idx) == gi) ? vote : vip_reg[gi];
    end
    assign vvip_next = (wr_en && cls == CLS_VVIP) ? vote : vvip_reg;

    // Current value of the addressed bit, used by the tally to detect a flip.
    always_comb begin
        old_bit = 1'b0;
        case (ballot_cls_e'(cls))
            CLS_NP:   if (int'(idx) < NP_W) old_bit = np_reg[idx];
            CLS_VIP:  if (int'(idx) < VIP_W) old_bit = vip_reg[idx[VIP_IW-1:0]];
            CLS_VVIP: old_bit = vvip_reg;
            default:  old_bit = 1'b0;
        endcase
    end

    // Staging registers carry over between rounds; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            np_reg   <= '0;
            vip_reg  <= '0;
            vvip_reg <= 1'b0;
        end else begin
            np_reg   <= np_next;
            vip_reg  <= vip_next;
            vvip_reg <= vvip_next;
        end
    end

endmodule

// File: rtl/vote_ballot_driver.sv
// Ballot producer: collects ballots, tracks a weighted tally, publishes per round.
module vote_ballot_driver
    import vote_ballot_driver_pkg::*;
#(
    parameter int NP_W    = DEF_NP_W,
    parameter int VIP_W   = DEF_VIP_W,
    parameter int W_NP    = DEF_W_NP,
    parameter int W_VIP   = DEF_W_VIP,
    parameter int W_VVIP  = DEF_W_VVIP,
    parameter int TALLY_W = DEF_TALLY_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_class,
    input  logic [IDX_W-1:0]   in_index,
    input  logic               in_vote,
    input  logic               in_last,
    output logic [NP_W-1:0]    np,
    output logic [VIP_W-1:0]   vip,
    output logic               vvip,
    output logic [TALLY_W-1:0] tally,
    output logic               pub_valid,
    output logic [7:0]         round_cnt,
    output logic               err
);

    drv_state_e         state_reg;
    logic               in_ready_reg;
    logic [NP_W-1:0]    np_reg;
    logic [VIP_W-1:0]   vip_reg;
    logic               vvip_reg;
    logic [TALLY_W-1:0] tally_reg;
    logic               pub_valid_reg;
    logic [7:0]         round_cnt_reg;
    logic               err_reg;
    logic [TALLY_W-1:0] tally_stage_reg;
    logic [TALLY_W-1:0] tally_stage_next;

    logic               accept;
    logic               legal;
    logic               wr_en;
    logic               old_bit;
    logic [TALLY_W-1:0] weight;
    logic [NP_W-1:0]    np_next;
    logic [VIP_W-1:0]   vip_next;
    logic               vvip_next;

    assign accept = in_valid && in_ready_reg;
    assign legal  = ballot_legal(in_class, in_index, NP_W, VIP_W);
    assign wr_en  = accept && legal;

    vote_ballot_driver_stage_bank #(
        .NP_W  (NP_W),
        .VIP_W (VIP_W)
    ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .cls       (in_class),
        .idx       (in_index),
        .vote      (in_vote),
        .old_bit   (old_bit),
        .np_next   (np_next),
        .vip_next  (vip_next),
        .vvip_next (vvip_next)
    );

    // Class weight and flip-only tally update; a flip can never push it out of range.
    always_comb begin
        weight = '0;
        case (ballot_cls_e'(in_class))
            CLS_NP:   weight = TALLY_W'(W_NP);
            CLS_VIP:  weight = TALLY_W'(W_VIP);
            CLS_VVIP: weight = TALLY_W'(W_VVIP);
            default:  weight = '0;
        endcase
        tally_stage_next = tally_stage_reg;
        if (wr_en && (old_bit != in_vote)) begin
            tally_stage_next = in_vote ? (tally_stage_reg + weight) : (tally_stage_reg - weight);
        end
    end

    // Round FSM; the closing ballot's own effect is folded into the published snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            in_ready_reg    <= 1'b1;
            np_reg          <= '0;
            vip_reg         <= '0;
            vvip_reg        <= 1'b0;
            tally_reg       <= '0;
            pub_valid_reg   <= 1'b0;
            round_cnt_reg   <= '0;
            err_reg         <= 1'b0;
            tally_stage_reg <= '0;
        end else begin
            tally_stage_reg <= tally_stage_next;
            pub_valid_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_COLLECT: begin
                    if (accept) begin
                        if (!legal) err_reg <= 1'b1;
                        if (in_last) begin
                            np_reg        <= np_next;
                            vip_reg       <= vip_next;
                            vvip_reg      <= vvip_next;
                            tally_reg     <= tally_stage_next;
                            pub_valid_reg <= 1'b1;
                            round_cnt_reg <= round_cnt_reg + 8'd1;
                            in_ready_reg  <= 1'b0;
                            state_reg     <= ST_PUBLISH;
                        end else begin
                            state_reg <= ST_COLLECT;
                        end
                    end
                end
                default: begin
                    in_ready_reg <= 1'b1;
                    state_reg    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign np        = np_reg;
    assign vip       = vip_reg;
    assign vvip      = vvip_reg;
    assign tally     = tally_reg;
    assign pub_valid = pub_valid_reg;
    assign round_cnt = round_cnt_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_vote_ballot_driver.sv
// Directed bench for vote_ballot_driver with a popcount-weighted reference tally.
module tb_vote_ballot_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_class = 2'd0;
    logic [4:0]  in_index = 5'd0;
    logic        in_vote = 1'b0;
    logic        in_last = 1'b0;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [7:0]  tally;
    logic        pub_valid;
    logic [7:0]  round_cnt;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    // Bench model of the staged vectors.
    logic [31:0] m_np   = '0;
    logic [7:0]  m_vip  = '0;
    logic        m_vvip = 1'b0;

    vote_ballot_driver dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_index  (in_index),
        .in_vote   (in_vote),
        .in_last   (in_last),
        .np        (np),
        .vip       (vip),
        .vvip      (vvip),
        .tally     (tally),
        .pub_valid (pub_valid),
        .round_cnt (round_cnt),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_tally();
        return $countones(m_np) + 4 * $countones(m_vip) + 16 * int'(m_vvip);
    endfunction

    // Present one ballot, wait (bounded) for in_ready, and return #1 after the accepting edge.
    task automatic send(input int cls, input int idx, input bit vote, input bit last);
        int waited;
        in_valid = 1'b1;
        in_class = 2'(cls);
        in_index = 5'(idx);
        in_vote  = vote;
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 8) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            chk("send_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (cls == 0) m_np[idx] = vote;
        else if (cls == 1 && idx < 8) m_vip[idx] = vote;
        else if (cls == 2 && idx == 0) m_vvip = vote;
    endtask

    // Check a publish cycle against the model and the reference tally.
    task automatic chk_pub(input string tag, input int exp_round);
        $display("publish %s: np=%h vip=%h vvip=%0d tally=%0d round=%0d", tag, np, vip, vvip, tally, round_cnt);
        chk({tag, "_pub_valid"}, 64'(pub_valid), 64'd1);
        chk({tag, "_np"}, 64'(np), 64'(m_np));
        chk({tag, "_vip"}, 64'(vip), 64'(m_vip));
        chk({tag, "_vvip"}, 64'(vvip), 64'(m_vvip));
        chk({tag, "_tally_ref"}, 64'(tally), 64'(ref_tally()));
        chk({tag, "_round"}, 64'(round_cnt), 64'(exp_round & 255));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_np"}, 64'(np), 64'd0);
        chk({tag, "_vip"}, 64'(vip), 64'd0);
        chk({tag, "_vvip"}, 64'(vvip), 64'd0);
        chk({tag, "_tally"}, 64'(tally), 64'd0);
        chk({tag, "_round"}, 64'(round_cnt), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_pub_valid"}, 64'(pub_valid), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        // 1: reset for three cycles
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_zero("reset");

        // 2: three np votes then vip 2 closing the round
        send(0, 0, 1'b1, 1'b0);
        send(0, 5, 1'b1, 1'b0);
        chk("r1_pub_hold", 64'(np), 64'd0);
        send(0, 31, 1'b1, 1'b0);
        send(1, 2, 1'b1, 1'b1);
        chk("r1_np_const", 64'(np), 64'h8000_0021);
        chk("r1_vip_const", 64'(vip), 64'h04);
        chk("r1_tally_const", 64'(tally), 64'd7);
        chk("r1_in_ready", 64'(in_ready), 64'd0);
        chk_pub("r1", 1);
        @(posedge clk); #1;
        chk("r1_pulse_end", 64'(pub_valid), 64'd0);
        chk("r1_ready_back", 64'(in_ready), 64'd1);

        // 3: vvip yes, withdraw np 5, repeat np 0
        send(2, 0, 1'b1, 1'b0);
        chk("r2_pub_hold", 64'(tally), 64'd7);
        send(0, 5, 1'b0, 1'b0);
        send(0, 0, 1'b1, 1'b1);
        chk("r2_np_const", 64'(np), 64'h8000_0001);
        chk("r2_vvip_const", 64'(vvip), 64'd1);
        chk("r2_tally_const", 64'(tally), 64'd22);
        chk_pub("r2", 2);
        @(posedge clk); #1;

        // 4: illegal ballots are ignored but flag err
        send(3, 0, 1'b1, 1'b0);
        chk("r3_err_set", 64'(err), 64'd1);
        send(1, 9, 1'b1, 1'b0);
        send(2, 3, 1'b0, 1'b0);
        send(0, 1, 1'b1, 1'b1);
        chk("r3_np_const", 64'(np), 64'h8000_0003);
        chk("r3_tally_const", 64'(tally), 64'd23);
        chk("r3_err_sticky", 64'(err), 64'd1);
        chk_pub("r3", 3);
        @(posedge clk); #1;
        send(3, 7, 1'b1, 1'b1);
        chk("r4_tally_const", 64'(tally), 64'd23);
        chk_pub("r4", 4);
        @(posedge clk); #1;

        // 5: backpressure through PUBLISH
        send(0, 2, 1'b1, 1'b1);
        chk("r5_tally_const", 64'(tally), 64'd24);
        chk_pub("r5", 5);
        in_valid = 1'b1; in_class = 2'd0; in_index = 5'd3; in_vote = 1'b1; in_last = 1'b0;
        chk("bp_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_ready_high", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        m_np[3] = 1'b1;
        send(0, 4, 1'b1, 1'b1);
        chk("r6_np_const", 64'(np), 64'h8000_001F);
        chk("r6_tally_const", 64'(tally), 64'd26);
        chk_pub("r6", 6);
        @(posedge clk); #1;

        // Reset mid-round
        send(0, 6, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_np = '0; m_vip = '0; m_vvip = 1'b0;
        chk_zero("rst_mid");

        // Reset during PUBLISH: pulse is cut and nothing is published
        send(1, 0, 1'b1, 1'b1);
        chk("rp_pub_seen", 64'(pub_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_np = '0; m_vip = '0; m_vvip = 1'b0;
        chk_zero("rst_pub");

        // 6: fill every voter, expect the full-scale tally
        for (int i = 0; i < 32; i++) send(0, i, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) send(1, i, 1'b1, 1'b0);
        send(2, 0, 1'b1, 1'b1);
        chk("full_tally_const", 64'(tally), 64'd80);
        chk("full_np_const", 64'(np), 64'hFFFF_FFFF);
        chk("full_vip_const", 64'(vip), 64'hFF);
        chk_pub("full", 1);
        @(posedge clk); #1;

        // 256 rounds of a no-change ballot: round_cnt wraps back to its start value
        for (int k = 1; k <= 256; k++) begin
            send(0, 0, 1'b1, 1'b1);
            chk("wrap_pub_valid", 64'(pub_valid), 64'd1);
            chk("wrap_tally_ref", 64'(tally), 64'(ref_tally()));
            if (k == 255) chk("wrap_zero", 64'(round_cnt), 64'd0);
            @(posedge clk); #1;
        end
        chk("wrap_round", 64'(round_cnt), 64'd1);
        chk("wrap_tally", 64'(tally), 64'd80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
